// File: rtl/sseg_frame_arbiter_pkg.sv
// Shared definitions for the 7-seg frame arbiter: FSM state encoding and frame field widths.
package sseg_frame_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SEND  = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  localparam int SSEG_HEX_W = 32;
  localparam int SSEG_PT_W  = 8;
  localparam int SSEG_LE_W  = 8;

endpackage

// File: rtl/sseg_frame_arbiter_rr_arbiter.sv
// Round-robin pick over NREQ level requests; the pointer advances past the winner on grant_en.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] req,
  input  logic            grant_en,
  output logic [NREQ-1:0] win,
  output logic [2:0]      win_idx,
  output logic            any
);

  logic [2:0]        rr_ptr;
  logic [2*NREQ-1:0] dbl;
  int                sum;

  // Rotate the request vector so bit 0 is the requester at rr_ptr.
  always_comb begin
    dbl     = {req, req} >> rr_ptr;
    sum     = 0;
    any     = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && dbl[k]) begin
        any = 1'b1;
        sum = int'(rr_ptr) + k;
        if (sum >= NREQ) sum = sum - NREQ;
        win_idx = 3'(sum);
      end
    end
    win = any ? (NREQ'(1) << win_idx) : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else if (grant_en && any) begin
      rr_ptr <= (win_idx == 3'(NREQ - 1)) ? 3'd0 : win_idx + 3'd1;
    end
  end

endmodule

// File: rtl/sseg_frame_arbiter.sv
// Shares one serial 7-seg display channel between NREQ requesters, with periodic self-refresh.
//
// state    | meaning
// ST_IDLE  | waiting for a request; refresh timer runs while no request is present
// ST_GRANT | one cycle: pulse gnt to the round-robin winner and latch its frame
// ST_SEND  | one cycle: pulse start, load the transmit timer
// ST_SHIFT | frame shifting out; requests wait until the timer reaches zero
module sseg_frame_arbiter
  import sseg_frame_arbiter_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TX_CYCLES      = 140,
  parameter int REFRESH_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*SSEG_HEX_W-1:0] req_hexs,
  input  logic [NREQ*SSEG_PT_W-1:0]  req_points,
  input  logic [NREQ*SSEG_LE_W-1:0]  req_les,
  output logic [NREQ-1:0]            gnt,
  output logic                       start,
  output logic [SSEG_HEX_W-1:0]      hexs,
  output logic [SSEG_PT_W-1:0]       points,
  output logic [SSEG_LE_W-1:0]       LEs,
  output logic                       busy,
  output logic [2:0]                 owner
);

  localparam logic [CNT_W-1:0] TX_LOAD  = CNT_W'(TX_CYCLES - 1);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_CYCLES - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  refresh_cnt;
  logic [CNT_W-1:0]  tx_cnt;
  logic [NREQ-1:0]   win;
  logic [2:0]        win_idx;
  logic              any;
  logic              grant_en;

  assign grant_en = (state == ST_GRANT);

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .grant_en (grant_en),
    .win      (win),
    .win_idx  (win_idx),
    .any      (any)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // A request always beats a refresh expiring in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (|req)                         state_nxt = ST_GRANT;
        else if (refresh_cnt == REF_LAST) state_nxt = ST_SEND;
      end
      ST_GRANT: state_nxt = any ? ST_SEND : ST_IDLE;
      ST_SEND:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (tx_cnt == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign gnt   = grant_en ? win : '0;
  assign start = (state == ST_SEND);
  assign busy  = (state == ST_SEND) || (state == ST_SHIFT);

  // tx_cnt holds TX_CYCLES-1 during SEND and counts down through SHIFT, so busy spans TX_CYCLES.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      refresh_cnt <= '0;
      tx_cnt      <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if ((|req) || (refresh_cnt == REF_LAST)) refresh_cnt <= '0;
        else                                     refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
      if (state_nxt == ST_SEND)       tx_cnt <= TX_LOAD;
      else if (busy && tx_cnt != '0)  tx_cnt <= tx_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hexs   <= '0;
      points <= '0;
      LEs    <= '0;
      owner  <= '0;
    end else if (grant_en && any) begin
      hexs   <= req_hexs[int'(win_idx)*SSEG_HEX_W +: SSEG_HEX_W];
      points <= req_points[int'(win_idx)*SSEG_PT_W +: SSEG_PT_W];
      LEs    <= req_les[int'(win_idx)*SSEG_LE_W +: SSEG_LE_W];
      owner  <= win_idx;
    end
  end

endmodule

// File: tb/tb_sseg_frame_arbiter.sv
// Randomised bench for sseg_frame_arbiter against a cycle-timeline reference model with a scoreboard.
module tb_sseg_frame_arbiter;

  localparam int NREQ = 3;
  localparam int TX   = 10;
  localparam int RF   = 20;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NREQ-1:0]   req;
  logic [NREQ*32-1:0] req_hexs;
  logic [NREQ*8-1:0] req_points;
  logic [NREQ*8-1:0] req_les;
  logic [NREQ-1:0]   gnt;
  logic              start;
  logic [31:0]       hexs;
  logic [7:0]        points;
  logic [7:0]        LEs;
  logic              busy;
  logic [2:0]        owner;

  sseg_frame_arbiter #(
    .NREQ(NREQ), .TX_CYCLES(TX), .REFRESH_CYCLES(RF), .CNT_W(16)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_hexs(req_hexs),
    .req_points(req_points), .req_les(req_les), .gnt(gnt), .start(start),
    .hexs(hexs), .points(points), .LEs(LEs), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic            start;
    logic            busy;
    logic [31:0]     hexs;
    logic [7:0]      points;
    logic [7:0]      les;
    logic [2:0]      owner;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: a timeline of scheduled events (grant cycle, start cycle, busy end).
  int          cyc = 0;
  int          gnt_at = -1, start_at = -1, busy_end = -1, run = 0, ptr = 0;
  logic [31:0] m_hexs = '0;
  logic [7:0]  m_points = '0, m_les = '0;
  int          m_owner = 0;
  bit          m_busy = 0;

  task automatic model_step();
    exp_t e;
    int   w;
    cyc++;
    e.gnt = '0; e.start = 1'b0; e.busy = 1'b0;
    if (!rstn) begin
      gnt_at = -1; start_at = -1; busy_end = -1; run = 0; ptr = 0;
      m_hexs = '0; m_points = '0; m_les = '0; m_owner = 0;
    end
    e.hexs = m_hexs; e.points = m_points; e.les = m_les; e.owner = 3'(m_owner);
    if (rstn) begin
      if (cyc == gnt_at) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
        if (w >= 0) begin
          e.gnt    = NREQ'(1) << w;
          m_hexs   = req_hexs[32*w +: 32];
          m_points = req_points[8*w +: 8];
          m_les    = req_les[8*w +: 8];
          m_owner  = w;
          ptr      = (w + 1) % NREQ;
          start_at = cyc + 1;
        end
      end else if (cyc == start_at) begin
        e.start  = 1'b1;
        e.busy   = 1'b1;
        busy_end = cyc + TX - 1;
      end else if (cyc <= busy_end) begin
        e.busy = 1'b1;
      end else if (req != '0) begin
        gnt_at = cyc + 1;
        run    = 0;
      end else if (run == RF - 1) begin
        run      = 0;
        start_at = cyc + 1;
      end else begin
        run++;
      end
    end
    m_busy = e.busy;
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      model_step();
    end
  end

  // Monitor: every cycle the DUT presents its outputs, compare against the oldest expectation.
  initial begin
    exp_t e;
    int   ncyc = 0;
    int   last_start = -1;
    forever begin
      @(negedge clk);
      ncyc++;
      checks++;
      if (q.size() == 0) begin
        $display("FAIL scoreboard_empty cycle=%0d no expectation available", ncyc);
      end else begin
        e = q.pop_front();
        if (gnt === e.gnt && start === e.start && busy === e.busy && hexs === e.hexs &&
            points === e.points && LEs === e.les && owner === e.owner) begin
          passes++;
        end else begin
          $display("FAIL outputs cycle=%0d got gnt=%b start=%b busy=%b hexs=%h pts=%h les=%h owner=%0d expected gnt=%b start=%b busy=%b hexs=%h pts=%h les=%h owner=%0d",
                   ncyc, gnt, start, busy, hexs, points, LEs, owner,
                   e.gnt, e.start, e.busy, e.hexs, e.points, e.les, e.owner);
        end
      end
      if (!rstn) last_start = -1;
      if (start === 1'b1) begin
        if (last_start >= 0) begin
          checks++;
          if (ncyc - last_start >= TX + 2) passes++;
          else $display("FAIL start_spacing got=%0d required_min=%0d", ncyc - last_start, TX + 2);
        end
        last_start = ncyc;
      end
    end
  end

  logic [NREQ-1:0] g_seen;

  task automatic raise(input int i, input logic [31:0] v);
    req_hexs[32*i +: 32] = v;
    req_points[8*i +: 8] = 8'($urandom);
    req_les[8*i +: 8]    = 8'($urandom);
    req[i]               = 1'b1;
  endtask

  // One clock: drop any request granted last cycle (optionally re-raising it), then return at posedge+1.
  task automatic step(input bit rehold);
    @(negedge clk);
    g_seen = gnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (g_seen[i]) begin
        req[i] = 1'b0;
        if (rehold) raise(i, $urandom);
      end
  endtask

  initial begin
    int quiet = 0;
    int guard;
    rstn = 1'b0; req = '0; req_hexs = '0; req_points = '0; req_les = '0;
    repeat (3) step(0);
    rstn = 1'b1;

    // Idle long enough for the first refresh of the all-zero frame.
    repeat (RF + 5) step(0);

    // Single request with a known frame.
    raise(0, 32'h1234_5678);
    repeat (TX + 8) step(0);

    // Two requesters held continuously: grants alternate back to back.
    raise(0, $urandom);
    raise(1, $urandom);
    repeat (4 * (TX + 2)) step(1);
    repeat (TX + 4) step(0);

    // Request arriving mid-transmission waits for the shift to finish.
    raise(0, $urandom);
    repeat (5) step(0);
    raise(1, $urandom);
    repeat (2 * TX + 6) step(0);

    // Request in the very cycle the refresh timer expires.
    guard = 0;
    while (!(run == RF - 1 && req == '0 && !m_busy) && guard < 200) begin
      step(0);
      guard++;
    end
    checks++;
    if (guard < 200) passes++;
    else $display("FAIL refresh_align_timeout got=%0d cycles limit=%0d", guard, 200);
    raise(0, $urandom);
    repeat (TX + RF + 8) step(0);

    // Reset in the middle of a transmission with requester 1 left pending.
    raise(0, $urandom);
    guard = 0;
    while (!m_busy && guard < 50) begin
      step(0);
      guard++;
    end
    repeat (3) step(0);
    raise(1, $urandom);
    rstn = 1'b0;
    repeat (2) step(0);
    rstn = 1'b1;
    repeat (TX + 6) step(0);

    // Same again with both pending: requester 0 must win first after reset.
    raise(2, $urandom);
    guard = 0;
    while (!m_busy && guard < 50) begin
      step(0);
      guard++;
    end
    repeat (2) step(0);
    raise(0, $urandom);
    raise(1, $urandom);
    rstn = 1'b0;
    step(0);
    rstn = 1'b1;
    repeat (4 * TX) step(0);

    // Random traffic with occasional quiet stretches to provoke refreshes.
    repeat (2000) begin
      step(0);
      if (quiet > 0) quiet--;
      else if ($urandom_range(0, 149) == 0) quiet = RF + 10;
      else
        for (int i = 0; i < NREQ; i++)
          if (!req[i] && $urandom_range(0, 7) == 0) raise(i, $urandom);
    end
    req = '0;
    repeat (TX + 4) step(0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
